rf_wr_arbiter: RTL and testbench

Write-port controller for the 8x16 register file, which has a single write port. It shares that port between two writeback requesters (req0 = ALU writeback, req1 = memory-load writeback) using valid/ready handshakes and round-robin priority. It also runs a clear sequence that writes CLEAR_VAL into every register after reset, and again on request. It drives the register file's writeEn/writeRegSel/writeData inputs directly from registers.

---
 rtl/rf_wr_arbiter.sv | 83 ++++++++
 tb/tb_rf_wr_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin write-port arbiter with post-reset clear sequence for the 8x16 register file.
// Optional same-destination merge enabled by defining RF_WR_ARB_COLLIDE_EN.
module rf_wr_arbiter #(
  parameter int DATA_W = 16,
  parameter int SEL_W = 3,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              req0_valid,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_writeEn,
  output logic [SEL_W-1:0]  rf_writeRegSel,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              busy,
  output logic              collide
);
  typedef enum logic {CLEAR, ARB} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d, sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic we_q, we_d, rr_q, rr_d, col_q, col_d, arb, last, same;
  always_comb begin
    arb = state_q == ARB && !clear_req;
    last = cnt_q == SEL_W'(NUM_REGS - 1);
`ifdef RF_WR_ARB_COLLIDE_EN
    same = arb && req0_valid && req1_valid && req0_sel == req1_sel;
`else
    same = 1'b0;
`endif
    // a same-destination merge grants both; req1's load is later in program order and wins
    req0_ready = arb && req0_valid && (!req1_valid || !rr_q || same);
    req1_ready = arb && req1_valid && (!req0_valid || rr_q || same);
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = req0_ready || req1_ready;
    sel_d = req1_ready ? req1_sel : req0_ready ? req0_sel : sel_q;
    data_d = req1_ready ? req1_data : req0_ready ? req0_data : data_q;
    rr_d = same ? rr_q : req1_ready ? 1'b0 : req0_ready ? 1'b1 : rr_q;
    col_d = same;
    if (state_q == CLEAR) begin
      we_d = 1'b1;
      sel_d = cnt_q;
      data_d = CLEAR_VAL;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      state_d = last ? ARB : CLEAR;
    end else if (clear_req) begin
      state_d = CLEAR;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      rr_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      data_q <= '0;
      col_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      we_q <= we_d;
      sel_q <= sel_d;
      data_q <= data_d;
      col_q <= col_d;
    end
  end
  assign rf_writeEn = we_q;
  assign rf_writeRegSel = sel_q;
  assign rf_writeData = data_q;
  assign busy = state_q == CLEAR;
  assign collide = col_q;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: vector table plus hand sequences for clear, async reset and same-destination writes.
module tb_rf_wr_arbiter;
  logic clk = 1'b0, rst_n, clear_req, req0_valid, req1_valid;
  logic [2:0] req0_sel, req1_sel, rf_writeRegSel;
  logic [15:0] req0_data, req1_data, rf_writeData;
  logic req0_ready, req1_ready, rf_writeEn, busy, collide;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic clr, v0; logic [2:0] s0; logic [15:0] d0;
    logic v1; logic [2:0] s1; logic [15:0] d1;
    logic r0, r1;
  } vec_t;
  typedef struct {logic we; logic [2:0] sel; logic [15:0] data; logic col;} wr_t;
  wr_t exp_q[$];

  rf_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_writeEn(rf_writeEn), .rf_writeRegSel(rf_writeRegSel), .rf_writeData(rf_writeData),
    .busy(busy), .collide(collide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    clear_req = v.clr;
    req0_valid = v.v0; req0_sel = v.s0; req0_data = v.d0;
    req1_valid = v.v1; req1_sel = v.s1; req1_data = v.d1;
  endtask

  // one arbitration cycle: readies checked mid-cycle, the expected write is queued and checked after the edge
  task automatic tick(input vec_t v);
    wr_t e;
    drive(v);
    #2;
    chk("req0_ready", req0_ready, v.r0);
    chk("req1_ready", req1_ready, v.r1);
    e.we = v.r0 | v.r1;
    e.sel = v.r1 ? v.s1 : v.s0;
    e.data = v.r1 ? v.d1 : v.d0;
    e.col = v.r0 & v.r1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("writeEn", rf_writeEn, e.we);
    if (e.we) begin
      chk("writeRegSel", rf_writeRegSel, e.sel);
      chk("writeData", rf_writeData, e.data);
    end
    chk("collide", collide, e.col);
  endtask

  task automatic check_clear(input int n);
    for (int i = 0; i < n; i++) begin
      #2;
      chk("clear_ready0", req0_ready, 0);
      chk("clear_ready1", req1_ready, 0);
      @(posedge clk); #1;
      chk("clear_we", rf_writeEn, 1);
      chk("clear_sel", rf_writeRegSel, 16'(i));
      chk("clear_data", rf_writeData, 16'h0000);
      chk("clear_busy", busy, 16'(i != 7));
    end
  endtask

  task automatic check_reset();
    chk("rst_we", rf_writeEn, 0);
    chk("rst_sel", rf_writeRegSel, 0);
    chk("rst_data", rf_writeData, 0);
    chk("rst_busy", busy, 1);
    chk("rst_collide", collide, 0);
  endtask

  initial begin
    vec_t tbl [12] = '{
      '{1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0},
      '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0},
      '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1},
      '{1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b1, 1'b0},
      '{1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b0, 1'b1},
      '{1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b1, 1'b0},
      '{1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b0, 1'b1},
      '{1'b0, 1'b1, 3'd6, 16'h0666, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0},
      '{1'b0, 1'b1, 3'd7, 16'h0777, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0},
      '{1'b0, 1'b1, 3'd0, 16'hB000, 1'b1, 3'd7, 16'hB007, 1'b0, 1'b1},
      '{1'b0, 1'b1, 3'd0, 16'hB000, 1'b1, 3'd7, 16'hB007, 1'b1, 1'b0},
      '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0}
    };
    vec_t v;
    rst_n = 1'b0;
    v = '{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    drive(v);
    #12;
    check_reset();
    rst_n = 1'b1;
    check_clear(8);
    for (int i = 0; i < 12; i++) tick(tbl[i]);
    // clear_req while both wait; held clear_req during CLEAR must be ignored
    v = '{1'b1, 1'b1, 3'd3, 16'hC003, 1'b1, 3'd5, 16'hC005, 1'b0, 1'b0};
    tick(v);
    chk("busy_after_clear_req", busy, 1);
    check_clear(8);
    v = '{1'b0, 1'b1, 3'd3, 16'hC003, 1'b1, 3'd5, 16'hC005, 1'b0, 1'b1};
    tick(v);
    v = '{1'b0, 1'b1, 3'd3, 16'hC003, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
    tick(v);
    // async reset mid-clear at cnt=5
    v = '{1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    tick(v);
    clear_req = 1'b0;
    check_clear(5);
    #2 rst_n = 1'b0;
    #1 check_reset();
    #2 rst_n = 1'b1;
    check_clear(8);
    // async reset right after an accept discards the pending write
    v = '{1'b0, 1'b1, 3'd2, 16'hDEAD, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0};
    drive(v);
    #2 chk("pre_rst_ready0", req0_ready, 1);
    @(posedge clk); #1;
    chk("pre_rst_we", rf_writeEn, 1);
    rst_n = 1'b0;
    #1 check_reset();
    v = '{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    drive(v);
    #1 rst_n = 1'b1;
    check_clear(8);
    // same destination, rr_ptr=0 after reset
`ifdef RF_WR_ARB_COLLIDE_EN
    v = '{1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 16'h2222, 1'b1, 1'b1};
    tick(v);
    v = '{1'b0, 1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hA002, 1'b1, 1'b0};
    tick(v);
`else
    v = '{1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 16'h2222, 1'b1, 1'b0};
    tick(v);
    v = '{1'b0, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 16'h2222, 1'b0, 1'b1};
    tick(v);
`endif
    v = '{1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    tick(v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
